fpl_bank: RTL and testbench
===========================

// Module: fpl_bank
// PURPOSE
//  Multi-channel page-latch bank: NCH independent PAGE_W-bit page registers that drive the high address bits of NCH external windows.
//  Sits on the 8-bit bus (cs/re/we, bidirectional d) beside the host interface.
//  Adds three things: a write-unlock key sequence with timeout, per-channel auto-increment on a step strobe, and sticky wrap flags.
// PARAMETERS
//  NCH      2      number of page channels, 1..4
//  PAGE_W   6      page register width, 1..8
//  ADDR_W   3      register address width; map needs 4+NCH entries, so NCH<=4
//  ID       8'h46  value returned at address 0
//  TIMEOUT  16     cycles the ARMED state waits for the second key byte, >=2
// PORTS
//  clk    in     1             system clock, all state on rising edge
//  rst    in     1             asynchronous, active-low reset
//  cs     in     1             chip select
//  re     in     1             read enable; d is driven while cs&&re
//  we     in     1             write enable; a write occurs on each clk edge with cs&&we
//  addr   in     ADDR_W        register address
//  d      inout  8             data bus; high-Z when !(cs&&re)
//  step   in     NCH           per-channel increment strobe, one pulse = one step
//  out    out    NCH*PAGE_W    page values; channel c occupies [c*PAGE_W +: PAGE_W]
//  locked out    1             1 unless the key FSM is in OPEN
// BEHAVIOUR
//  Register map:
//   0 ID      R    ID
//   1 KEY     W    unlock key
//   2 CTRL    R/W  [NCH-1:0] autoinc enable per channel
//   3 STAT    R/W1C  [1:0] FSM state (0 LOCKED, 1 ARMED, 2 OPEN), [NCH+1:2] sticky wrap flags
//   4+c PAGE[c]  R/W  page of channel c, in d[PAGE_W-1:0]
//  Unused addresses read 8'h00; writes to them are ignored, except for the ARMED abort rule below.
//  Reads are combinational from cs&&re&&addr. Narrow fields read zero-extended.
//  Reset (rst low, asynchronous): all pages 0, CTRL 0, wrap flags 0, FSM LOCKED, timeout counter 0, locked=1, d high-Z.
//  Key FSM. Transitions take effect on the clk edge of the qualifying write:
//   LOCKED -> ARMED   on write KEY=8'h55; timeout counter loads TIMEOUT-1.
//   ARMED  -> OPEN    on write KEY=8'hAA.
//   ARMED  -> LOCKED  on any other write (any address or value), or when the counter reaches 0 with no write that cycle.
//   ARMED             counter decrements each cycle while waiting.
//   OPEN   -> LOCKED  on write KEY with any value other than 8'hAA. Writing 8'hAA in OPEN stays OPEN.
//  Write gating:
//   CTRL and PAGE writes take effect only in OPEN; otherwise they are silently dropped.
//   STAT W1C is accepted in any state. Writing 1 to bit 2+c clears wrap flag c.
//   Writes to STAT[1:0] and ID are ignored.
//  Auto-increment:
//   On a clk edge with step[c]=1 and CTRL[c]=1, PAGE[c] <= PAGE[c]+1 mod 2^PAGE_W.
//   Step is honoured in every FSM state; the lock does not gate it.
//   When PAGE[c] was all-ones, the increment wraps to 0 and sets wrap flag c.
//   Step with CTRL[c]=0 has no effect.
//  Simultaneous events:
//   Bus write to PAGE[c] and step[c] on the same edge: the write wins, no increment, wrap flag untouched.
//   W1C of flag c and a wrap of channel c on the same edge: the flag ends set (set wins).
//  Latency: page writes and steps appear on out one cycle after the edge; locked follows the FSM register.
//  Reset asserted mid-sequence (e.g. in ARMED) returns to LOCKED immediately, without waiting for clk.
// CONFIGURATION
//  FPL_READBACK_EN defined: CTRL, STAT and PAGE[c] read back as described above.
//  FPL_READBACK_EN undefined: addresses 2..4+NCH-1 read ID; write behaviour is unchanged, and out/locked still reflect the registers.
// TESTING
//  1. Reset, then write PAGE0=8'h15 without the key -> out[5:0]=0, locked=1; reading addr 0 gives 8'h46.
//  2. Write KEY 55, then KEY AA, then PAGE1=8'h2A -> locked=0 after the AA edge; out[11:6]=6'h2A one cycle after the page write.
//  3. Write KEY 55, then idle TIMEOUT cycles, then KEY AA -> FSM returns to LOCKED at timeout; AA is ignored; STAT[1:0]=0.
//  4. In OPEN, set CTRL=1 and PAGE0=6'h3E, then pulse step[0] twice -> PAGE0 goes 3F then 00; STAT[2]=1; writing STAT=8'h04 clears it.
//  5. Same edge: write PAGE0=5 and step[0]=1 -> PAGE0=5. Same edge: wrap and W1C -> flag set.
//  6. Assert rst low between clk edges while ARMED -> locked=1 and out=0 before the next edge. Repeat test 1 with FPL_READBACK_EN undefined: reading addr 4 gives 8'h46.

Source files
------------

// File: rtl/fpl_bank.sv
// Multi-channel page-latch bank on the 8-bit cs/re/we bus: key-unlocked page writes,
// per-channel auto-increment with sticky wrap flags. Register readback is enabled by FPL_READBACK_EN.
module fpl_bank #(
    parameter int          NCH     = 2,
    parameter int          PAGE_W  = 6,
    parameter int          ADDR_W  = 3,
    parameter logic [7:0]  ID      = 8'h46,
    parameter int          TIMEOUT = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cs,
    input  logic                    re,
    input  logic                    we,
    input  logic [ADDR_W-1:0]       addr,
    inout  wire  [7:0]              d,
    input  logic [NCH-1:0]          step,
    output logic [NCH*PAGE_W-1:0]   out,
    output logic                    locked
);

    localparam int CNT_W = $clog2(TIMEOUT);

    localparam logic [1:0] S_LOCKED = 2'd0;
    localparam logic [1:0] S_ARMED  = 2'd1;
    localparam logic [1:0] S_OPEN   = 2'd2;

    localparam logic [7:0] KEY_ARM  = 8'h55;
    localparam logic [7:0] KEY_OPEN = 8'hAA;

    logic [1:0]              state, state_n;
    logic [CNT_W-1:0]        cnt, cnt_n;
    logic [NCH-1:0]          ctrl;
    logic [NCH-1:0]          wrap;
    logic [NCH*PAGE_W-1:0]   pages;

    logic [31:0]             a_idx;
    logic                    wr;
    logic                    key_wr;
    logic                    ctrl_wr;
    logic [NCH-1:0]          pg_wr;
    logic [NCH-1:0]          pg_inc;
    logic [NCH-1:0]          wrap_set;
    logic [NCH-1:0]          wrap_clr;
    logic [7:0]              rdata;

    assign a_idx  = 32'(addr);
    assign wr     = cs && we;
    assign key_wr = wr && (a_idx == 32'd1);

    // Key FSM: ARMED aborts on any bus write other than the second key byte.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            S_LOCKED: begin
                if (key_wr && d == KEY_ARM) begin
                    state_n = S_ARMED;
                    cnt_n   = CNT_W'(TIMEOUT - 1);
                end
            end
            S_ARMED: begin
                if (wr) begin
                    state_n = (key_wr && d == KEY_OPEN) ? S_OPEN : S_LOCKED;
                    cnt_n   = '0;
                end else if (cnt == '0) begin
                    state_n = S_LOCKED;
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            S_OPEN: begin
                if (key_wr && d != KEY_OPEN) begin
                    state_n = S_LOCKED;
                end
            end
            default: begin
                state_n = S_LOCKED;
                cnt_n   = '0;
            end
        endcase
    end

    // Bus page write beats a same-edge step; a wrap beats a same-edge W1C.
    always_comb begin
        ctrl_wr  = wr && (state == S_OPEN) && (a_idx == 32'd2);
        pg_wr    = '0;
        pg_inc   = '0;
        wrap_set = '0;
        wrap_clr = '0;
        for (int c = 0; c < NCH; c++) begin
            pg_wr[c]    = wr && (state == S_OPEN) && (a_idx == 32'(4 + c));
            pg_inc[c]   = !pg_wr[c] && step[c] && ctrl[c];
            wrap_set[c] = pg_inc[c] && (&pages[c*PAGE_W +: PAGE_W]);
            wrap_clr[c] = wr && (a_idx == 32'd3) && d[2 + c];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_LOCKED;
            cnt   <= '0;
            ctrl  <= '0;
            wrap  <= '0;
            pages <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (ctrl_wr) begin
                ctrl <= d[NCH-1:0];
            end
            wrap <= (wrap & ~wrap_clr) | wrap_set;
            for (int c = 0; c < NCH; c++) begin
                if (pg_wr[c]) begin
                    pages[c*PAGE_W +: PAGE_W] <= d[PAGE_W-1:0];
                end else if (pg_inc[c]) begin
                    pages[c*PAGE_W +: PAGE_W] <= pages[c*PAGE_W +: PAGE_W] + PAGE_W'(1);
                end
            end
        end
    end

    always_comb begin
        rdata = 8'h00;
        if (a_idx == 32'd0) begin
            rdata = ID;
        end
`ifdef FPL_READBACK_EN
        else if (a_idx == 32'd2) begin
            rdata = 8'(ctrl);
        end else if (a_idx == 32'd3) begin
            rdata = 8'({wrap, state});
        end else begin
            for (int c = 0; c < NCH; c++) begin
                if (a_idx == 32'(4 + c)) begin
                    rdata = 8'(pages[c*PAGE_W +: PAGE_W]);
                end
            end
        end
`else
        // Without readback the whole control/page window mirrors the ID byte.
        else if (a_idx >= 32'd2 && a_idx < 32'(4 + NCH)) begin
            rdata = ID;
        end
`endif
    end

    assign d      = (cs && re) ? rdata : 8'bz;
    assign out    = pages;
    assign locked = (state != S_OPEN);

endmodule

// File: tb/tb_fpl_bank.sv
// Self-checking bench for fpl_bank: directed key/page/wrap scenarios followed by random bus
// traffic, all compared every cycle against a behavioural model of the register bank.
module tb_fpl_bank;

    localparam int         NCH     = 2;
    localparam int         PAGE_W  = 6;
    localparam int         ADDR_W  = 3;
    localparam logic [7:0] ID      = 8'h46;
    localparam int         TIMEOUT = 16;
    localparam int         PMOD    = 1 << PAGE_W;

    logic                    clk   = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    cs    = 1'b0;
    logic                    re    = 1'b0;
    logic                    we    = 1'b0;
    logic [ADDR_W-1:0]       addr  = '0;
    logic [7:0]              d_drv = 8'h00;
    logic                    d_oe  = 1'b0;
    logic [NCH-1:0]          step  = '0;
    wire  [7:0]              d;
    logic [NCH*PAGE_W-1:0]   out;
    logic                    locked;

    int checks = 0;
    int errors = 0;

    assign d = d_oe ? d_drv : 8'bz;

    fpl_bank #(
        .NCH(NCH), .PAGE_W(PAGE_W), .ADDR_W(ADDR_W), .ID(ID), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst_n), .cs(cs), .re(re), .we(we), .addr(addr),
        .d(d), .step(step), .out(out), .locked(locked)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // m_state: 0 locked, 1 armed, 2 open. m_age counts idle cycles spent armed.
    int              m_state = 0;
    int              m_age   = 0;
    int              m_page[NCH];
    bit [NCH-1:0]    m_ctrl  = '0;
    bit [NCH-1:0]    m_wrap  = '0;

    task automatic model_reset();
        m_state = 0;
        m_age   = 0;
        m_ctrl  = '0;
        m_wrap  = '0;
        for (int c = 0; c < NCH; c++) m_page[c] = 0;
    endtask

    task automatic model_step();
        bit           wr;
        int           a;
        int           v;
        int           nstate;
        bit [NCH-1:0] nwrap;
        bit [NCH-1:0] nctrl;
        wr     = cs && we;
        a      = int'(addr);
        v      = int'(d_drv);
        nstate = m_state;
        if (m_state == 0) begin
            if (wr && a == 1 && v == 'h55) begin
                nstate = 1;
                m_age  = 0;
            end
        end else if (m_state == 1) begin
            if (wr) begin
                nstate = (a == 1 && v == 'hAA) ? 2 : 0;
            end else begin
                m_age = m_age + 1;
                if (m_age >= TIMEOUT) nstate = 0;
            end
        end else begin
            if (wr && a == 1 && v != 'hAA) nstate = 0;
        end
        nwrap = m_wrap;
        for (int c = 0; c < NCH; c++) begin
            if (wr && a == 3 && ((v >> (2 + c)) & 1) == 1) nwrap[c] = 1'b0;
        end
        for (int c = 0; c < NCH; c++) begin
            if (m_state == 2 && wr && a == 4 + c) begin
                m_page[c] = v % PMOD;
            end else if (step[c] && m_ctrl[c]) begin
                m_page[c] = (m_page[c] + 1) % PMOD;
                if (m_page[c] == 0) nwrap[c] = 1'b1;
            end
        end
        nctrl = m_ctrl;
        if (m_state == 2 && wr && a == 2) nctrl = NCH'(v);
        m_ctrl  = nctrl;
        m_wrap  = nwrap;
        m_state = nstate;
    endtask

    function automatic int model_read(int a);
        if (a == 0) return int'(ID);
`ifdef FPL_READBACK_EN
        if (a == 2) return int'(m_ctrl);
        if (a == 3) return (int'(m_wrap) << 2) | m_state;
        if (a >= 4 && a < 4 + NCH) return m_page[a - 4];
`else
        if (a >= 2 && a < 4 + NCH) return int'(ID);
`endif
        return 0;
    endfunction

    function automatic logic [NCH*PAGE_W-1:0] model_out();
        logic [NCH*PAGE_W-1:0] o;
        o = '0;
        for (int c = 0; c < NCH; c++) o[c*PAGE_W +: PAGE_W] = PAGE_W'(m_page[c]);
        return o;
    endfunction

    initial model_reset();

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else        model_step();
    end

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always begin
        @(posedge clk);
        #2;
        if (rst_n) begin
            check("out", 64'(out), 64'(model_out()));
            check("locked", 64'(locked), 64'(m_state != 2));
            if (cs && re) check("rdata", 64'(d), 64'(model_read(int'(addr))));
        end
    end

    // ---------------- drivers ----------------
    task automatic bus_write(input int a, input logic [7:0] v);
        @(negedge clk);
        cs = 1'b1; we = 1'b1; re = 1'b0; addr = ADDR_W'(a); d_drv = v; d_oe = 1'b1;
        @(negedge clk);
        cs = 1'b0; we = 1'b0; d_oe = 1'b0;
    endtask

    task automatic bus_read(input int a, output logic [7:0] v);
        @(negedge clk);
        cs = 1'b1; re = 1'b1; we = 1'b0; d_oe = 1'b0; addr = ADDR_W'(a);
        #2;
        v = d;
        @(negedge clk);
        cs = 1'b0; re = 1'b0;
    endtask

    task automatic pulse_step(input logic [NCH-1:0] m);
        @(negedge clk);
        step = m;
        @(negedge clk);
        step = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Write and step presented on the same edge.
    task automatic write_with_step(input int a, input logic [7:0] v, input logic [NCH-1:0] m);
        @(negedge clk);
        cs = 1'b1; we = 1'b1; re = 1'b0; addr = ADDR_W'(a); d_drv = v; d_oe = 1'b1; step = m;
        @(negedge clk);
        cs = 1'b0; we = 1'b0; d_oe = 1'b0; step = '0;
    endtask

    // ---------------- stimulus ----------------
    logic [7:0] rv;

    initial begin
        rst_n = 1'b0;
        idle(3);
        rst_n = 1'b1;

        // reset state and dropped page write while locked
        check("rst_out", 64'(out), 64'd0);
        check("rst_locked", 64'(locked), 64'd1);
        bus_write(4, 8'h15);
        check("t1_out", 64'(out), 64'd0);
        check("t1_locked", 64'(locked), 64'd1);
        bus_read(0, rv);
        check("t1_id", 64'(rv), 64'h46);
        bus_read(4, rv);
`ifdef FPL_READBACK_EN
        check("t1_page_rd", 64'(rv), 64'h00);
`else
        check("t1_mirror_id", 64'(rv), 64'h46);
`endif

        // unlock, then page 1 write
        bus_write(1, 8'h55);
        check("t2_armed_locked", 64'(locked), 64'd1);
        bus_write(1, 8'hAA);
        check("t2_open", 64'(locked), 64'd0);
        bus_write(5, 8'h2A);
        check("t2_page1", 64'(out[11:6]), 64'h2A);

        // relock; timeout boundary: TIMEOUT-1 idle cycles still opens
        bus_write(1, 8'h00);
        check("t3_relock", 64'(locked), 64'd1);
        bus_write(1, 8'h55);
        idle(TIMEOUT - 2);
        bus_write(1, 8'hAA);
        check("t3_just_in_time", 64'(locked), 64'd0);
        bus_write(1, 8'h13);
        bus_write(1, 8'h55);
        idle(TIMEOUT - 1);
        bus_write(1, 8'hAA);
        check("t3_timed_out", 64'(locked), 64'd1);
`ifdef FPL_READBACK_EN
        bus_read(3, rv);
        check("t3_stat", 64'(rv), 64'h00);
`endif
        // abort from ARMED by a non-key write
        bus_write(1, 8'h55);
        bus_write(2, 8'h01);
        bus_write(1, 8'hAA);
        check("t3_abort", 64'(locked), 64'd1);

        // auto-increment with wrap
        bus_write(1, 8'h55);
        bus_write(1, 8'hAA);
        bus_write(2, 8'h01);
        bus_write(4, 8'h3E);
        check("t4_load", 64'(out[5:0]), 64'h3E);
        pulse_step(2'b01);
        check("t4_step1", 64'(out[5:0]), 64'h3F);
        pulse_step(2'b01);
        check("t4_wrap", 64'(out[5:0]), 64'h00);
        pulse_step(2'b10);
        check("t4_ch1_disabled", 64'(out[11:6]), 64'h2A);
`ifdef FPL_READBACK_EN
        bus_read(3, rv);
        check("t4_stat_flag", 64'(rv), 64'h06);
        bus_write(3, 8'h04);
        bus_read(3, rv);
        check("t4_stat_clr", 64'(rv), 64'h02);
`else
        bus_write(3, 8'h04);
`endif

        // same-edge priorities
        write_with_step(4, 8'h05, 2'b01);
        check("t5_write_wins", 64'(out[5:0]), 64'h05);
        bus_write(4, 8'h3F);
        write_with_step(3, 8'h04, 2'b01);
        check("t5_wrap_w1c_out", 64'(out[5:0]), 64'h00);
`ifdef FPL_READBACK_EN
        bus_read(3, rv);
        check("t5_set_wins", 64'(rv), 64'h06);
`endif
        pulse_step(2'b01);
        check("t5_after_wrap", 64'(out[5:0]), 64'h01);

        // asynchronous reset while armed
        bus_write(1, 8'h00);
        bus_write(1, 8'h55);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_async_locked", 64'(locked), 64'd1);
        check("t6_async_out", 64'(out), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bus_write(1, 8'hAA);
        check("t6_post_reset_locked", 64'(locked), 64'd1);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            int r;
            @(negedge clk);
            cs = 1'b0; we = 1'b0; re = 1'b0; d_oe = 1'b0;
            step = ($urandom_range(0, 2) == 0) ? NCH'($urandom_range(0, (1 << NCH) - 1)) : '0;
            r = $urandom_range(0, 9);
            if (r < 4) begin
                cs = 1'b1; we = 1'b1; d_oe = 1'b1;
                if ($urandom_range(0, 1) == 0) begin
                    addr = ADDR_W'(1);
                    case ($urandom_range(0, 3))
                        0, 1:    d_drv = 8'h55;
                        2:       d_drv = 8'hAA;
                        default: d_drv = 8'($urandom_range(0, 255));
                    endcase
                end else begin
                    addr  = ADDR_W'($urandom_range(0, (1 << ADDR_W) - 1));
                    d_drv = 8'($urandom_range(0, 255));
                end
            end else if (r < 6) begin
                cs = 1'b1; re = 1'b1;
                addr = ADDR_W'($urandom_range(0, (1 << ADDR_W) - 1));
            end
        end
        @(negedge clk);
        cs = 1'b0; we = 1'b0; re = 1'b0; d_oe = 1'b0; step = '0;
        idle(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
